// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory request/response channel between an
// instruction-fetch port and a data port. One transaction is outstanding at a
// time; a request is granted one cycle after it is seen in IDLE. Ties go either
// to the data port (FIXED_PRIO = 1) or to the port opposite the previous grant
// (FIXED_PRIO = 0). The arbiter holds no copy of the request; it routes it
// straight through while in the address phase.
//
// Ports (packed vectors, MSB first):
//   clk    in   single clock, all state on posedge
//   resetn in   synchronous active-low reset
//   ireq   in   [32:0]  {valid, addr[31:0]}
//   iresp  out  [33:0]  {addr_ok, data_ok, data[31:0]}
//   dreq   in   [71:0]  {valid, addr[31:0], size[2:0], strobe[3:0], data[31:0]}
//   dresp  out  [33:0]  {addr_ok, data_ok, data[31:0]}
//   mreq   out  [71:0]  same layout as dreq
//   mresp  in   [33:0]  same layout as iresp
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [32:0] ireq,
  output logic [33:0] iresp,
  input  logic [71:0] dreq,
  output logic [33:0] dresp,
  output logic [71:0] mreq,
  input  logic [33:0] mresp
);

  typedef enum logic [2:0] {
    StIdle,
    StIAddr,
    StIData,
    StDAddr,
    StDData
  } state_e;

  state_e state_q, state_d;
  // 0: instruction port granted last, 1: data port granted last
  logic   last_grant_q, last_grant_d;

  logic        i_valid;
  logic [31:0] i_addr;
  logic        d_valid;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_data;

  assign i_valid   = ireq[32];
  assign i_addr    = ireq[31:0];
  assign d_valid   = dreq[71];
  assign m_addr_ok = mresp[33];
  assign m_data_ok = mresp[32];
  assign m_data    = mresp[31:0];

  // Next-state and grant bookkeeping.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid && d_valid) begin
          // Round-robin: after an I grant (0) the data port wins the tie.
          state_d = (FIXED_PRIO || !last_grant_q) ? StDAddr : StIAddr;
        end else if (d_valid) begin
          state_d = StDAddr;
        end else if (i_valid) begin
          state_d = StIAddr;
        end
        if (state_d != StIdle) begin
          last_grant_d = (state_d == StDAddr);
        end
      end
      StIAddr: begin
        // A withdrawn request abandons the grant without forwarding anything.
        if (!i_valid) begin
          state_d = StIdle;
        end else if (m_addr_ok) begin
          state_d = m_data_ok ? StIdle : StIData;
        end
      end
      StIData: begin
        if (m_data_ok) begin
          state_d = StIdle;
        end
      end
      StDAddr: begin
        if (!d_valid) begin
          state_d = StIdle;
        end else if (m_addr_ok) begin
          state_d = m_data_ok ? StIdle : StDData;
        end
      end
      StDData: begin
        if (m_data_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Routing. Outputs are forced quiet while reset is asserted so that nothing
  // leaks out of a transaction that is being abandoned.
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (resetn) begin
      unique case (state_q)
        StIAddr: begin
          mreq = {i_valid, i_addr, 3'b010, 4'h0, 32'h0};
          if (i_valid) begin
            iresp = mresp;
          end
        end
        StIData: begin
          iresp = {1'b0, m_data_ok, m_data};
        end
        StDAddr: begin
          mreq = dreq;
          if (d_valid) begin
            dresp = mresp;
          end
        end
        StDData: begin
          dresp = {1'b0, m_data_ok, m_data};
        end
        default: begin
          mreq = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances (round-robin and fixed
// priority) share the requester stimulus; sel picks which one the memory
// model talks to. Expected grants are queued as requests are posted and
// popped when the shared bus shows a new transaction.
module tb_mem_arbiter;

  typedef struct {
    bit          is_d;
    logic [71:0] req;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic [32:0] ireq;
  logic [71:0] dreq;
  logic [33:0] mresp;

  logic [33:0] iresp_rr, dresp_rr, mresp_rr;
  logic [71:0] mreq_rr;
  logic [33:0] iresp_fp, dresp_fp, mresp_fp;
  logic [71:0] mreq_fp;
  logic [33:0] cur_iresp, cur_dresp;
  logic [71:0] cur_mreq;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk   (clk),
    .resetn(resetn),
    .ireq  (ireq),
    .iresp (iresp_rr),
    .dreq  (dreq),
    .dresp (dresp_rr),
    .mreq  (mreq_rr),
    .mresp (mresp_rr)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk   (clk),
    .resetn(resetn),
    .ireq  (ireq),
    .iresp (iresp_fp),
    .dreq  (dreq),
    .dresp (dresp_fp),
    .mreq  (mreq_fp),
    .mresp (mresp_fp)
  );

  always_comb begin
    mresp_rr  = sel ? 34'h0 : mresp;
    mresp_fp  = sel ? mresp : 34'h0;
    cur_mreq  = sel ? mreq_fp : mreq_rr;
    cur_iresp = sel ? iresp_fp : iresp_rr;
    cur_dresp = sel ? dresp_fp : dresp_rr;
  end

  function automatic logic [71:0] mk_i(input logic [31:0] a);
    return {1'b1, a, 3'b010, 4'h0, 32'h0};
  endfunction

  function automatic logic [71:0] mk_d(input logic [31:0] a);
    return {1'b1, a, 3'b010, 4'hf, ~a};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge (drive phase).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    ireq = (iq.size() > 0) ? {1'b1, iq[0]} : 33'h0;
    dreq = (dq.size() > 0) ? mk_d(dq[0]) : 72'h0;
  endtask

  task automatic set_mresp(input logic a, input logic d, input logic [31:0] data);
    mresp = {a, d, data};
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e.is_d  = 1'b0;
    e.req   = mk_i(a);
    e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e.is_d  = 1'b1;
    e.req   = mk_d(a);
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Granted port must mirror the memory response; the other must stay silent.
  task automatic check_resps(input bit is_d);
    chk("granted_resp", 72'(is_d ? cur_dresp : cur_iresp), 72'(mresp));
    chk("other_resp_silent", 72'(is_d ? cur_iresp : cur_dresp), 72'h0);
  endtask

  // Serve the next transaction: expect it w cycles from now, stall addr_ok
  // for a_lat cycles, then return data d_lat cycles later (0 = same cycle).
  task automatic serve(input int w, input int a_lat, input int d_lat);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    n = 0;
    #1;
    while (cur_mreq[71] !== 1'b1 && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk("grant_latency", 72'(n), 72'(w));
    if (cur_mreq[71] !== 1'b1) return;
    for (int k = 0; k <= a_lat; k++) begin
      if (k > 0) begin
        cyc();
        #1;
      end
      chk(e.is_d ? "mreq_d" : "mreq_i", cur_mreq, e.req);
      if (k == a_lat) set_mresp(1'b1, d_lat == 0, (d_lat == 0) ? e.rdata : 32'h0);
      #1;
      check_resps(e.is_d);
    end
    cyc();
    set_mresp(1'b0, 1'b0, 32'h0);
    if (e.is_d) begin
      if (dq.size() > 0) dq.delete(0);
    end else begin
      if (iq.size() > 0) iq.delete(0);
    end
    drive_reqs();
    if (d_lat > 0) begin
      for (int k = 1; k <= d_lat; k++) begin
        if (k > 1) cyc();
        #1;
        chk("data_phase_mreq_valid", 72'(cur_mreq[71]), 72'h0);
        if (k == d_lat) set_mresp(1'b0, 1'b1, e.rdata);
        #1;
        check_resps(e.is_d);
      end
      cyc();
      set_mresp(1'b0, 1'b0, 32'h0);
    end
  endtask

  // Reset with both requesters active; outputs must stay quiet throughout.
  task automatic do_reset();
    resetn = 1'b0;
    set_mresp(1'b0, 1'b0, 32'h0);
    iq.delete();
    dq.delete();
    sb.delete();
    ireq = {1'b1, 32'h1111_0000};
    dreq = mk_d(32'h2222_0000);
    repeat (2) cyc();
    #1;
    chk("rst_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    chk("rst_iresp", 72'(cur_iresp), 72'h0);
    chk("rst_dresp", 72'(cur_dresp), 72'h0);
    drive_reqs();
    resetn = 1'b1;
    cyc();
    #1;
    chk("post_rst_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    chk("post_rst_resps", 72'({cur_iresp, cur_dresp}), 72'h0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    sel    = 1'b0;
    resetn = 1'b0;
    ireq   = '0;
    dreq   = '0;
    mresp  = '0;

    // Single fetch: addr_ok two cycles after request, data four cycles after.
    do_reset();
    iq.push_back(32'hbfc0_0000);
    push_i(32'hbfc0_0000, 32'h3c08_0001);
    drive_reqs();
    serve(1, 1, 2);

    // Tie straight after reset: data port first, then instruction port.
    do_reset();
    dq.push_back(32'h8000_0040);
    iq.push_back(32'hbfc0_0004);
    push_d(32'h8000_0040, 32'h1234_5678);
    push_i(32'hbfc0_0004, 32'h2400_0001);
    drive_reqs();
    serve(1, 0, 1);
    serve(1, 1, 1);

    // Sustained tie, round-robin: D, I, D, I.
    do_reset();
    dq.push_back(32'h8000_0100);
    dq.push_back(32'h8000_0104);
    iq.push_back(32'hbfc0_0100);
    iq.push_back(32'hbfc0_0104);
    push_d(32'h8000_0100, 32'haaaa_0001);
    push_i(32'hbfc0_0100, 32'hbbbb_0001);
    push_d(32'h8000_0104, 32'haaaa_0002);
    push_i(32'hbfc0_0104, 32'hbbbb_0002);
    drive_reqs();
    serve(1, 0, 1);
    serve(1, 1, 2);
    serve(1, 2, 1);
    serve(1, 0, 0);

    // Sustained tie, fixed priority: data port keeps winning.
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dq.push_back(32'h9000_0000 + 32'(k * 4));
      push_d(32'h9000_0000 + 32'(k * 4), 32'hcccc_0000 + 32'(k));
    end
    iq.push_back(32'hbfc0_0200);
    push_i(32'hbfc0_0200, 32'hdddd_0000);
    drive_reqs();
    for (int k = 0; k < 5; k++) serve(1, k % 2, 1 + (k % 3));
    sel = 1'b0;

    // addr_ok and data_ok together in the address phase, then back-to-back.
    do_reset();
    dq.push_back(32'h8000_0300);
    dq.push_back(32'h8000_0304);
    push_d(32'h8000_0300, 32'h5555_aaaa);
    push_d(32'h8000_0304, 32'h6666_bbbb);
    drive_reqs();
    serve(1, 0, 0);
    serve(1, 2, 1);

    // Requester withdraws before addr_ok: grant is dropped, nothing forwarded.
    do_reset();
    iq.push_back(32'h0000_1000);
    drive_reqs();
    #1;
    chk("drop_idle_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    cyc();
    #1;
    chk("drop_granted", cur_mreq, mk_i(32'h0000_1000));
    cyc();
    iq.delete();
    drive_reqs();
    #1;
    chk("drop_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    chk("drop_iresp", 72'(cur_iresp), 72'h0);
    cyc();
    dq.push_back(32'h0000_2000);
    push_d(32'h0000_2000, 32'h0bad_f00d);
    drive_reqs();
    serve(1, 0, 1);

    // Reset while waiting for fetch data: late data_ok must be dropped.
    do_reset();
    iq.push_back(32'h0000_3000);
    drive_reqs();
    cyc();
    #1;
    chk("rd_granted", cur_mreq, mk_i(32'h0000_3000));
    set_mresp(1'b1, 1'b0, 32'h0);
    #1;
    chk("rd_addr_ok", 72'(cur_iresp), 72'({1'b1, 1'b0, 32'h0}));
    cyc();
    iq.delete();
    drive_reqs();
    set_mresp(1'b0, 1'b0, 32'h0);
    #1;
    chk("rd_data_phase_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    cyc();
    resetn = 1'b0;
    #1;
    chk("rd_in_reset_iresp", 72'(cur_iresp), 72'h0);
    cyc();
    resetn = 1'b1;
    set_mresp(1'b0, 1'b1, 32'hdead_beef);
    #1;
    chk("rd_late_iresp", 72'(cur_iresp), 72'h0);
    chk("rd_late_dresp", 72'(cur_dresp), 72'h0);
    chk("rd_late_mreq_valid", 72'(cur_mreq[71]), 72'h0);
    cyc();
    set_mresp(1'b0, 1'b0, 32'h0);

    chk("scoreboard_drained", 72'(sb.size()), 72'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
